alu_operand_sequencer: RTL

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_operand_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encodings,
// operation-code constants and the legality check on a 4-bit code.
package alu_pkg;

    // Sequencer states (3-bit encoding, kept as plain constants)
    localparam logic [2:0] ST_GET_CTRL = 3'd0;
    localparam logic [2:0] ST_GET_A    = 3'd1;
    localparam logic [2:0] ST_GET_B    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_RESULT   = 3'd4;

    // Operation codes understood by the compare/logic stage
    localparam logic [3:0] OP_TRA  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_GT   = 4'd9;
    localparam logic [3:0] OP_LT   = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;

    // Bounds of the defined code range
    localparam logic [3:0] OP_MIN = OP_TRA;
    localparam logic [3:0] OP_MAX = OP_EQ;

    // A code outside OP_MIN..OP_MAX is not executed by the stage
    function automatic logic op_is_illegal(input logic [3:0] code);
        return (code < OP_MIN) || (code > OP_MAX);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects a control beat and two operand beats from a byte stream, presents
// them to an external compare/logic stage for one cycle, captures the result
// with zero/negative/illegal flags and holds it until the consumer takes it.
//
// Handshakes: a beat moves on a rising edge where in_valid && in_ready; a
// result moves on a rising edge where res_valid && res_ready. Neither side
// may make valid depend on ready; res_ready outside RESULT has no effect.
module alu_operand_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [3:0] op_ctrl,
    input  logic [7:0] alu_s,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic       res_neg,
    output logic       res_illegal,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] op_count
);

    logic [2:0] state;
    logic       beat;
    logic       take;
    logic       unused_hi;

    // Upper nibble of the control beat carries no meaning
    assign unused_hi = ^in_data[7:4];

    // Ready only while gathering beats, and never during a reset cycle
    assign in_ready = !rst && ((state == ST_GET_CTRL) ||
                               (state == ST_GET_A)    ||
                               (state == ST_GET_B));
    assign res_valid = !rst && (state == ST_RESULT);

    assign beat = in_valid && in_ready;
    assign take = res_valid && res_ready;

    // Sequencer FSM with operand, result and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_GET_CTRL;
            op_a        <= 8'h00;
            op_b        <= 8'h00;
            op_ctrl     <= 4'h0;
            res_data    <= 8'h00;
            res_zero    <= 1'b0;
            res_neg     <= 1'b0;
            res_illegal <= 1'b0;
            op_count    <= 8'h00;
        end else begin
            case (state)
                ST_GET_CTRL: begin
                    if (beat) begin
                        op_ctrl <= in_data[3:0];
                        state   <= ST_GET_A;
                    end
                end
                ST_GET_A: begin
                    if (beat) begin
                        op_a  <= in_data;
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (beat) begin
                        op_b  <= in_data;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Operands have been stable for a full cycle; sample the stage
                    res_data    <= alu_s;
                    res_zero    <= (alu_s == 8'h00);
                    res_neg     <= alu_s[7];
                    res_illegal <= op_is_illegal(op_ctrl);
                    state       <= ST_RESULT;
                end
                ST_RESULT: begin
                    // No bypass: the next control beat waits for GET_CTRL
                    if (take) begin
                        op_count <= op_count + 8'd1;
                        state    <= ST_GET_CTRL;
                    end
                end
                default: begin
                    state <= ST_GET_CTRL;
                end
            endcase
        end
    end

endmodule
